uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares the single UART transmitter (wen/data/tre interface) between NREQ byte-stream requesters, e.g. logic-analyzer dump engine, debug console and status reporter.
- Grants whole messages: a requester keeps the transmitter until its byte flagged last has been handed over, so bytes from different sources never interleave.
- Sits between the requesters and the transmitter inside the UART top level, in the sys_clk domain.

Parameters:
- NREQ, 3, number of requesters (2..8).
- GUARD_CYCLES, 4, max cycles to wait for tre_i to fall after a write before proceeding anyway (1..255).
- STALL_TIMEOUT, 65535, cycles the granted requester may hold req low mid-message before its grant is revoked (1..65535).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_l  in  1  reset, asynchronous, active-low.
- req_i  in  NREQ  per-requester "byte valid".
- data_i  in  8*NREQ  byte of requester k on data_i[8k+7:8k].
- last_i  in  NREQ  byte of requester k is last of its message.
- ack_o  out  NREQ  one-cycle pulse: byte of requester k accepted; requester may then change data/last.
- grant_o  out  NREQ  one-hot current owner, zero when idle.
- drop_o  out  NREQ  one-cycle pulse: grant of requester k revoked by stall timeout.
- wen_o  out  1  one-cycle write strobe to transmitter.
- tx_data_o  out  8  byte to transmitter, valid with wen_o.
- tre_i  in  1  transmitter empty/ready (high = may write).
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- All outputs registered. Reset (async, sys_rst_l low): state IDLE, wen_o 0, tx_data_o 0x00, ack_o/grant_o/drop_o 0, busy_o 0, round-robin pointer ptr=0, counters 0. Reset mid-byte abandons the message; transmitter recovers on its own reset.
- States: IDLE, SEND, WAIT_FALL, WAIT_RISE.
- IDLE: if tre_i=1 and req_i!=0, pick first set bit searching ptr, ptr+1, ... wrapping mod NREQ; grant_o one-hot next cycle, -> SEND. No request or tre_i=0: stay.
- SEND, owner g: if req_i[g]=1 in cycle t, then at t+1 wen_o=1, tx_data_o=data_i[g], ack_o[g]=1 (all single-cycle), last flag captured internally, -> WAIT_FALL. Minimum grant-to-wen latency: 2 cycles from req seen in IDLE.
- SEND with req_i[g]=0: stall counter increments; on reaching STALL_TIMEOUT, drop_o[g] pulses, grant_o clears, ptr=(g+1) mod NREQ, -> IDLE. Counter clears on every accepted byte.
- WAIT_FALL: -> WAIT_RISE when tre_i=0 or after GUARD_CYCLES cycles, whichever first.
- WAIT_RISE: wait tre_i=1. Then if captured last=1: grant_o clears, ptr=(g+1) mod NREQ, -> IDLE; else -> SEND.
- Requests from non-owners are ignored until IDLE; no starvation: each requester waits at most NREQ-1 messages.
- Message of one byte (last on first byte) is legal. ack_o never pulses for a non-granted requester; at most one ack_o bit high per cycle.
- Simultaneous req at IDLE: round robin decides; ptr only advances on message end or drop.
- wen_o is never asserted while tre_i=0 sampled in the preceding cycle.

Test Plan:
- Reset, single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> three wen_o pulses with those bytes in order, each after tre_i rises, three ack_o[0] pulses, grant_o returns 0, ptr=1.
- req_i=3'b111 all with 2-byte messages, from reset -> transmit order req0,req1,req2, no interleaving; second round starting with req0 again.
- Requester 1 granted, drops req after first byte, STALL_TIMEOUT=16 -> drop_o[1] pulse exactly 16 cycles after SEND entry with req low, grant cleared, requester 2 served next.
- Transmitter model never lowers tre_i, GUARD_CYCLES=4 -> wen_o pulses spaced by at least 6 cycles, no hang.
- One-byte message with req1 and req2 asserted while req0 owns -> ptr order 1 then 2, ack only to owner, at most one ack_o bit per cycle.
- Assert sys_rst_l low during WAIT_RISE -> all outputs 0 immediately (asynchronously), IDLE after release, next message starts from requester 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte streams.
// A requester owns the transmitter for a whole message, until its last byte.
module uart_tx_scheduler #(
  parameter int NREQ          = 3,
  parameter int GUARD_CYCLES  = 4,
  parameter int STALL_TIMEOUT = 65535,
  localparam int PW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] data_i,
  input  logic [NREQ-1:0]   last_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   drop_o,
  output logic              wen_o,
  output logic [7:0]        tx_data_o,
  input  logic              tre_i,
  output logic              busy_o,
  output logic [1:0]        state_o,
  output logic [PW-1:0]     ptr_o
);

  // Handshake: req_i[k] holds data_i/last_i stable until ack_o[k] pulses for one
  // cycle; only then may requester k present its next byte or drop req_i[k].

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_FALL = 2'd2,
    WAIT_RISE = 2'd3
  } state_t;

  localparam logic [15:0] STALL_MAX = 16'(STALL_TIMEOUT - 1);
  localparam logic [7:0]  GUARD_MAX = 8'(GUARD_CYCLES - 1);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic            last_q;
  logic [15:0]     stall_cnt;
  logic [7:0]      guard_cnt;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  int              cand;
  logic [PW-1:0]   owner_inc;
  logic            req_owner;
  logic            last_owner;
  logic [7:0]      data_owner;
  logic [NREQ-1:0] pick_onehot;

  // Search ptr, ptr+1, ... wrapping; walking downwards leaves the closest hit.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NREQ;
      if (req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  assign owner_inc   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
  assign req_owner   = req_i[owner];
  assign last_owner  = last_i[owner];
  assign data_owner  = data_i[{owner, 3'b000} +: 8];
  assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
  assign state_o     = state;
  assign ptr_o       = ptr;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      last_q    <= 1'b0;
      stall_cnt <= '0;
      guard_cnt <= '0;
      ack_o     <= '0;
      grant_o   <= '0;
      drop_o    <= '0;
      wen_o     <= 1'b0;
      tx_data_o <= 8'h00;
      busy_o    <= 1'b0;
    end else begin
      wen_o  <= 1'b0;
      ack_o  <= '0;
      drop_o <= '0;
      case (state)
        IDLE: begin
          if (tre_i && pick_valid) begin
            owner     <= pick_idx;
            grant_o   <= pick_onehot;
            stall_cnt <= '0;
            busy_o    <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // tre_i is re-checked so a write never follows a low tre_i sample.
          if (req_owner && tre_i) begin
            wen_o     <= 1'b1;
            tx_data_o <= data_owner;
            ack_o     <= grant_o;
            last_q    <= last_owner;
            stall_cnt <= '0;
            guard_cnt <= '0;
            state     <= WAIT_FALL;
          end else if (!req_owner) begin
            if (stall_cnt == STALL_MAX) begin
              drop_o    <= grant_o;
              grant_o   <= '0;
              ptr       <= owner_inc;
              stall_cnt <= '0;
              busy_o    <= 1'b0;
              state     <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end
        end
        WAIT_FALL: begin
          // A transmitter that never drops tre_i must not hang the scheduler.
          if (!tre_i || guard_cnt == GUARD_MAX) begin
            guard_cnt <= '0;
            state     <= WAIT_RISE;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        WAIT_RISE: begin
          if (tre_i) begin
            if (last_q) begin
              grant_o <= '0;
              ptr     <= owner_inc;
              busy_o  <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester and transmitter models,
// an ordered scoreboard of (source, byte) writes and per-step assertions.
module tb_uart_tx_scheduler;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_l = 1'b0;
  logic [2:0] req_i     = '0;
  logic [23:0] data_i   = '0;
  logic [2:0] last_i    = '0;
  logic       tre_i     = 1'b1;
  logic [2:0] ack_o, grant_o, drop_o;
  logic       wen_o;
  logic [7:0] tx_data_o;
  logic       busy_o;
  logic [1:0] state_o;
  logic [1:0] ptr_o;

  uart_tx_scheduler #(
    .NREQ(3), .GUARD_CYCLES(4), .STALL_TIMEOUT(16)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
    .req_i(req_i), .data_i(data_i), .last_i(last_i),
    .ack_o(ack_o), .grant_o(grant_o), .drop_o(drop_o),
    .wen_o(wen_o), .tx_data_o(tx_data_o), .tre_i(tre_i),
    .busy_o(busy_o), .state_o(state_o), .ptr_o(ptr_o)
  );

  // clock / reset
  initial forever #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg_byte [3][16];
  logic       msg_last [3][16];
  int         msg_len  [3];
  int         msg_pos  [3];
  int         ack_cnt  [3];
  int         tx_hold;
  int         hold_cnt;
  int         cyc;
  logic       tre_at_edge;
  int         send_entry_cyc;
  logic [1:0] prev_state;
  logic [2:0] drop_seen;
  bit         gap_en;
  bit         last_wen_valid;
  int         last_wen_cyc;
  int         gap_cnt;
  logic [9:0] exp_q [$];
  logic [9:0] exp_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] owner_of(input logic [2:0] g);
    logic [1:0] r;
    r = 2'd3;
    for (int k = 0; k < 3; k++) if (g == (3'b001 << k)) r = 2'(k);
    return r;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input int k, input logic [7:0] b, input logic l);
    msg_byte[k][msg_len[k]] = b;
    msg_last[k][msg_len[k]] = l;
    msg_len[k]++;
  endtask

  task automatic clear_models();
    for (int k = 0; k < 3; k++) begin
      msg_len[k] = 0;
      msg_pos[k] = 0;
      ack_cnt[k] = 0;
    end
    exp_q.delete();
    drop_seen      = '0;
    last_wen_valid = 1'b0;
    gap_cnt        = 0;
  endtask

  task automatic do_reset();
    sys_rst_l = 1'b0;
    clear_models();
    repeat (3) step();
    sys_rst_l = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && busy_o == 1'b0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size() == 0 && busy_o == 1'b0), 1);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    int n;
    n = 0;
    while (state_o !== s && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(state_o), 32'(s));
  endtask

  // cycle counter and tre_i as seen by the DUT at each active edge
  initial begin
    cyc = 0;
    forever begin
      @(posedge sys_clk);
      cyc++;
      tre_at_edge = tre_i;
    end
  end

  // requester driver: present bytes, advance on ack
  initial forever begin
    @(negedge sys_clk);
    for (int k = 0; k < 3; k++) begin
      if (ack_o[k] && msg_pos[k] < msg_len[k]) msg_pos[k]++;
      if (msg_pos[k] < msg_len[k]) begin
        req_i[k]        = 1'b1;
        data_i[8*k +: 8] = msg_byte[k][msg_pos[k]];
        last_i[k]       = msg_last[k][msg_pos[k]];
      end else begin
        req_i[k]        = 1'b0;
        data_i[8*k +: 8] = 8'h00;
        last_i[k]       = 1'b0;
      end
    end
  end

  // transmitter model: tre_i low for tx_hold cycles after each write (0 = never)
  initial begin
    hold_cnt = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_l) begin
        tre_i    = 1'b1;
        hold_cnt = 0;
      end else if (wen_o && tx_hold > 0) begin
        tre_i    = 1'b0;
        hold_cnt = tx_hold;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) tre_i = 1'b1;
      end
    end
  end

  // scoreboard / protocol monitor
  initial begin
    prev_state = 2'd0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_l) begin
        if (wen_o) begin
          if (exp_q.size() > 0) exp_v = exp_q.pop_front();
          else exp_v = 10'h3ff;
          check("tx_byte", 32'({owner_of(grant_o), tx_data_o}), 32'(exp_v));
          check("tre_before_wen", 32'(tre_at_edge), 1);
          check("wen_ack", 32'(ack_o), 32'(grant_o));
          if (gap_en && last_wen_valid) begin
            check("wen_gap_ge6", 32'((cyc - last_wen_cyc) >= 6), 1);
            gap_cnt++;
          end
          last_wen_cyc   = cyc;
          last_wen_valid = 1'b1;
        end
        if (ack_o != 3'b000) begin
          check("ack_onehot", 32'($onehot0(ack_o)), 1);
          check("ack_owner", 32'(ack_o & ~grant_o), 0);
          for (int k = 0; k < 3; k++) if (ack_o[k]) ack_cnt[k]++;
        end
        if (state_o == 2'd1 && prev_state != 2'd1) send_entry_cyc = cyc;
        if (drop_o != 3'b000) begin
          check("drop_delay", 32'(cyc - send_entry_cyc), 16);
          check("drop_grant", 32'(grant_o), 0);
          drop_seen = drop_seen | drop_o;
        end
        prev_state = state_o;
      end else begin
        prev_state = 2'd0;
      end
    end
  end

  initial begin
    tx_hold = 3;
    gap_en  = 1'b0;
    do_reset();
    check("rst_grant", 32'(grant_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_wen", 32'(wen_o), 0);
    check("rst_txdata", 32'(tx_data_o), 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_ptr", 32'(ptr_o), 0);

    // single requester, three bytes
    load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
    exp_q.push_back({2'd0, 8'h41});
    exp_q.push_back({2'd0, 8'h42});
    exp_q.push_back({2'd0, 8'h43});
    step();
    check("t1_grant", 32'(grant_o), 32'(3'b001));
    check("t1_busy", 32'(busy_o), 1);
    check("t1_no_wen_yet", 32'(wen_o), 0);
    step();
    check("t1_wen", 32'(wen_o), 1);
    check("t1_first_byte", 32'(tx_data_o), 32'(8'h41));
    check("t1_first_ack", 32'(ack_o), 32'(3'b001));
    wait_idle("t1_done", 200);
    check("t1_ack_cnt", 32'(ack_cnt[0]), 3);
    check("t1_ptr", 32'(ptr_o), 1);
    check("t1_grant_clear", 32'(grant_o), 0);

    // all three request together, req0 has a second message
    do_reset();
    tx_hold = 2;
    load(0, 8'h10, 1'b0); load(0, 8'h11, 1'b1); load(0, 8'h12, 1'b0); load(0, 8'h13, 1'b1);
    load(1, 8'h20, 1'b0); load(1, 8'h21, 1'b1);
    load(2, 8'h30, 1'b0); load(2, 8'h31, 1'b1);
    exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd1, 8'h20}); exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd2, 8'h30}); exp_q.push_back({2'd2, 8'h31});
    exp_q.push_back({2'd0, 8'h12}); exp_q.push_back({2'd0, 8'h13});
    wait_idle("t2_done", 400);
    check("t2_ptr", 32'(ptr_o), 1);
    check("t2_ack0", 32'(ack_cnt[0]), 4);
    check("t2_ack1", 32'(ack_cnt[1]), 2);
    check("t2_ack2", 32'(ack_cnt[2]), 2);

    // requester 1 stalls mid-message and is dropped; requester 2 follows
    do_reset();
    tx_hold = 3;
    load(1, 8'h55, 1'b0);
    load(2, 8'h66, 1'b1);
    exp_q.push_back({2'd1, 8'h55});
    exp_q.push_back({2'd2, 8'h66});
    wait_idle("t3_done", 300);
    check("t3_drop_seen", 32'(drop_seen), 32'(3'b010));
    check("t3_ptr", 32'(ptr_o), 0);
    check("t3_ack1", 32'(ack_cnt[1]), 1);
    check("t3_ack2", 32'(ack_cnt[2]), 1);

    // transmitter never lowers tre_i: guard timeout paces the writes
    do_reset();
    tx_hold = 0;
    gap_en  = 1'b1;
    load(0, 8'hD0, 1'b0); load(0, 8'hD1, 1'b0); load(0, 8'hD2, 1'b1);
    exp_q.push_back({2'd0, 8'hD0});
    exp_q.push_back({2'd0, 8'hD1});
    exp_q.push_back({2'd0, 8'hD2});
    wait_idle("t4_done", 200);
    gap_en = 1'b0;
    check("t4_gap_count", 32'(gap_cnt), 2);
    check("t4_ack0", 32'(ack_cnt[0]), 3);

    // one-byte messages from 1 and 2 arrive while 0 owns
    do_reset();
    tx_hold = 2;
    load(0, 8'h70, 1'b0); load(0, 8'h71, 1'b1);
    exp_q.push_back({2'd0, 8'h70}); exp_q.push_back({2'd0, 8'h71});
    exp_q.push_back({2'd1, 8'h81}); exp_q.push_back({2'd2, 8'h92});
    step();
    check("t5_grant0", 32'(grant_o), 32'(3'b001));
    load(1, 8'h81, 1'b1);
    load(2, 8'h92, 1'b1);
    wait_idle("t5_done", 300);
    check("t5_ack0", 32'(ack_cnt[0]), 2);
    check("t5_ack1", 32'(ack_cnt[1]), 1);
    check("t5_ack2", 32'(ack_cnt[2]), 1);
    check("t5_ptr", 32'(ptr_o), 0);

    // asynchronous reset while waiting for tre_i to rise
    do_reset();
    tx_hold = 5;
    load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b1);
    exp_q.push_back({2'd0, 8'hA1});
    wait_state("t6_in_wait_rise", 2'd3, 100);
    #2;
    sys_rst_l = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant_o), 0);
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_state", 32'(state_o), 0);
    check("t6_rst_txdata", 32'(tx_data_o), 0);
    check("t6_rst_wen", 32'(wen_o), 0);
    check("t6_rst_ack", 32'(ack_o), 0);
    clear_models();
    step();
    step();
    sys_rst_l = 1'b1;
    step();
    check("t6_ptr_after_rst", 32'(ptr_o), 0);
    load(2, 8'hC0, 1'b1);
    load(0, 8'hB0, 1'b1);
    exp_q.push_back({2'd0, 8'hB0});
    exp_q.push_back({2'd2, 8'hC0});
    wait_idle("t6_done", 300);
    check("t6_ack0", 32'(ack_cnt[0]), 1);
    check("t6_ack2", 32'(ack_cnt[2]), 1);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
